// File: rtl/sound_cmd_mailbox.sv
// rtl/sound_cmd_mailbox.sv - 68k <-> 6502 sound command/response mailbox
//
// The 68k pushes command bytes into a small FIFO; each accepted push requests
// an NMI pulse to the 6502. The 6502 pops commands and returns a one-byte
// response through a latch that the 68k reads.
//
// Ports:
//   phi0, SNDRST_b          clock, async active-low reset
//   WRmain_b, RDmain_b      68k command-write / response-read strobes (active low)
//   main_din, main_dout     68k command byte in, response latch out
//   cmd_full, rsp_valid     68k status
//   RD68k_b, WR68k_b, SBA0  6502 strobes (active low) and data/status select
//   SDout, SDin_mbx, SDin_oe 6502 write data, read data, read drive enable
//   SNDNMI_b                NMI to the 6502, active low
//   main_irq_b              only with MBX_RSP_IRQ_EN: registered ~rsp_valid
//
// Optional feature macro: MBX_RSP_IRQ_EN
`timescale 1ns/1ps

module sound_cmd_mailbox #(
    parameter int DEPTH     = 4,
    parameter int NMI_PULSE = 4,
    parameter int NMI_GAP   = 2
) (
    input  logic       phi0,
    input  logic       SNDRST_b,
    input  logic       WRmain_b,
    input  logic       RDmain_b,
    input  logic [7:0] main_din,
    output logic [7:0] main_dout,
    output logic       cmd_full,
    output logic       rsp_valid,
    input  logic       RD68k_b,
    input  logic       WR68k_b,
    input  logic       SBA0,
    input  logic [7:0] SDout,
    output logic [7:0] SDin_mbx,
    output logic       SDin_oe,
    output logic       SNDNMI_b
`ifdef MBX_RSP_IRQ_EN
    ,
    output logic       main_irq_b
`endif
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} nmi_state_t;

    logic          wrmain_hist_q, rdmain_hist_q, rd68k_hist_q, wr68k_hist_q;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]    count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          rsp_lost_q, rsp_lost_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          nmi_req_q, nmi_req_d;
    nmi_state_t    nmi_state_q;
    logic [3:0]    nmi_cnt_q;
    logic          sndnmi_b_q;

    logic wrmain_fall, rdmain_rise, rd68k_rise, wr68k_fall;
    logic flush, rsp_wr, empty, full, pop, push_ok, push_drop;
    logic [7:0] status;

    always_comb begin
        // Edges compare the live strobe against last cycle's sample so that
        // the action lands on the posedge of the detecting cycle.
        wrmain_fall = wrmain_hist_q & ~WRmain_b;
        rdmain_rise = ~rdmain_hist_q & RDmain_b;
        rd68k_rise  = ~rd68k_hist_q & RD68k_b;
        wr68k_fall  = wr68k_hist_q & ~WR68k_b;

        flush  = wr68k_fall & SBA0;
        rsp_wr = wr68k_fall & ~SBA0;
        empty  = (count_q == 3'd0);
        full   = (count_q == 3'(DEPTH));

        pop       = rd68k_rise & ~SBA0 & ~empty & ~flush;
        // A simultaneous pop frees a slot, so a push onto a full FIFO still fits.
        push_ok   = wrmain_fall & ~flush & (~full | pop);
        push_drop = wrmain_fall & ~flush & full & ~pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 3'd0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {2'b00, push_ok} - {2'b00, pop};
        end

        overrun_d = overrun_q;
        if (flush)                   overrun_d = 1'b0;
        else if (push_drop)          overrun_d = 1'b1;
        else if (rd68k_rise & SBA0)  overrun_d = 1'b0;

        rsp_lost_d = rsp_lost_q;
        if (flush)                       rsp_lost_d = 1'b0;
        else if (rsp_wr & rsp_valid_q)   rsp_lost_d = 1'b1;

        // A 6502 response write outranks a same-cycle 68k read acknowledge.
        rsp_valid_d = rsp_valid_q;
        if (rsp_wr)           rsp_valid_d = 1'b1;
        else if (rdmain_rise) rsp_valid_d = 1'b0;

        rsp_data_d = rsp_wr ? SDout : rsp_data_q;

        // The FSM consumes the request whenever it sits in IDLE; a push in the
        // same cycle re-arms it so that push is not lost.
        nmi_req_d = nmi_req_q;
        if (flush)                        nmi_req_d = 1'b0;
        else if (push_ok)                 nmi_req_d = 1'b1;
        else if (nmi_state_q == S_IDLE)   nmi_req_d = 1'b0;

        status = {~empty, full, overrun_q, rsp_lost_q, 1'b0, count_q};
    end

    always_ff @(posedge phi0 or negedge SNDRST_b) begin
        if (!SNDRST_b) begin
            wrmain_hist_q <= 1'b1;
            rdmain_hist_q <= 1'b1;
            rd68k_hist_q  <= 1'b1;
            wr68k_hist_q  <= 1'b1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= 3'd0;
            overrun_q     <= 1'b0;
            rsp_lost_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 8'h00;
            nmi_req_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            wrmain_hist_q <= WRmain_b;
            rdmain_hist_q <= RDmain_b;
            rd68k_hist_q  <= RD68k_b;
            wr68k_hist_q  <= WR68k_b;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overrun_q     <= overrun_d;
            rsp_lost_q    <= rsp_lost_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            nmi_req_q     <= nmi_req_d;
            if (push_ok) mem_q[wr_ptr_q] <= main_din;
        end
    end

    // NMI pulse generator: the counter is loaded with length-1 on entry to a
    // timed state and the state is left when it reaches zero.
    always_ff @(posedge phi0 or negedge SNDRST_b) begin
        if (!SNDRST_b) begin
            nmi_state_q <= S_IDLE;
            nmi_cnt_q   <= 4'd0;
            sndnmi_b_q  <= 1'b1;
        end else begin
            case (nmi_state_q)
                S_IDLE: begin
                    if (nmi_req_q) begin
                        nmi_state_q <= S_PULSE;
                        nmi_cnt_q   <= 4'(NMI_PULSE - 1);
                        sndnmi_b_q  <= 1'b0;
                    end
                end
                S_PULSE: begin
                    if (nmi_cnt_q == 4'd0) begin
                        nmi_state_q <= S_GAP;
                        nmi_cnt_q   <= 4'(NMI_GAP - 1);
                        sndnmi_b_q  <= 1'b1;
                    end else begin
                        nmi_cnt_q <= nmi_cnt_q - 4'd1;
                    end
                end
                S_GAP: begin
                    if (nmi_cnt_q == 4'd0) nmi_state_q <= S_IDLE;
                    else                   nmi_cnt_q   <= nmi_cnt_q - 4'd1;
                end
                default: begin
                    nmi_state_q <= S_IDLE;
                    sndnmi_b_q  <= 1'b1;
                end
            endcase
        end
    end

`ifdef MBX_RSP_IRQ_EN
    logic irq_b_q, irq_b_d;

    always_comb begin
        irq_b_d = ~rsp_valid_d;
    end

    always_ff @(posedge phi0 or negedge SNDRST_b) begin
        if (!SNDRST_b) irq_b_q <= 1'b1;
        else           irq_b_q <= irq_b_d;
    end

    assign main_irq_b = irq_b_q;
`endif

    assign main_dout = rsp_data_q;
    assign cmd_full  = full;
    assign rsp_valid = rsp_valid_q;
    assign SDin_oe   = ~RD68k_b;
    assign SDin_mbx  = SBA0 ? status : (empty ? 8'hFF : mem_q[rd_ptr_q]);
    assign SNDNMI_b  = sndnmi_b_q;

endmodule
